// File: rtl/matmul_mac_sched.sv
// matmul_mac_sched
// Computes the 2x2 product C = A x B with one shared, externally arbitrated
// WIDTH x WIDTH multiplier. A start pulse in IDLE latches both operand
// matrices. The eight partial products are then issued one per granted cycle.
// The four results are published together with a one-cycle done pulse.
//
// Ports:
//   clk, rst          clock (rising edge) and synchronous active-high reset
//   start             job request, sampled only in IDLE
//   a_in, b_in        packed matrices, element i at [i*WIDTH +: WIDTH]
//                     (0=x00, 1=x01, 2=x10, 3=x11)
//   mul_req/mul_gnt   multiplier handshake; a step is consumed on req && gnt
//   mul_a/mul_b       multiplier operands, 0 outside RUN
//   mul_p             same-cycle product of mul_a*mul_b
//   busy              job in progress
//   done              one-cycle pulse when c00..c11 have just been updated
//   c00..c11          registered unsigned results, 2*WIDTH+1 bits each
module matmul_mac_sched #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*WIDTH-1:0]   a_in,
  input  logic [4*WIDTH-1:0]   b_in,
  output logic                 mul_req,
  input  logic                 mul_gnt,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_p,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH:0]     c00,
  output logic [2*WIDTH:0]     c01,
  output logic [2*WIDTH:0]     c10,
  output logic [2*WIDTH:0]     c11
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state, state_nx;
  logic [2:0]           step;
  logic [4*WIDTH-1:0]   a_lat, b_lat;
  logic [2*WIDTH:0]     acc;
  logic [2*WIDTH:0]     shadow [4];
  logic [2*WIDTH:0]     sum;
  logic [1:0]           a_idx, b_idx;
  logic                 fire;

  // Zero-extend a product to the result width.
  function automatic logic [2*WIDTH:0] widen(input logic [2*WIDTH-1:0] p);
    return {1'b0, p};
  endfunction

  // Full-precision sum of two products; the extra bit absorbs the carry.
  function automatic logic [2*WIDTH:0] acc_add(input logic [2*WIDTH:0] a,
                                               input logic [2*WIDTH-1:0] p);
    return a + widen(p);
  endfunction

  assign fire = (state == RUN) && mul_gnt;
  assign sum  = acc_add(acc, mul_p);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= fire && (step == 3'd7);
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (fire && step == 3'd7) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs. Step bits map to the operand pair: A row = step[2],
  // inner index k = step[0], B column = step[1].
  always_comb begin
    busy    = (state == RUN);
    mul_req = (state == RUN);
    a_idx   = {step[2], step[0]};
    b_idx   = {step[0], step[1]};
    mul_a   = '0;
    mul_b   = '0;
    if (state == RUN) begin
      mul_a = a_lat[int'(a_idx)*WIDTH +: WIDTH];
      mul_b = b_lat[int'(b_idx)*WIDTH +: WIDTH];
    end
  end

  // Datapath: operand latch, accumulate, publish on the final step
  always_ff @(posedge clk) begin
    if (rst) begin
      step  <= '0;
      a_lat <= '0;
      b_lat <= '0;
      acc   <= '0;
      for (int i = 0; i < 4; i++) shadow[i] <= '0;
      c00   <= '0;
      c01   <= '0;
      c10   <= '0;
      c11   <= '0;
    end else if (state == IDLE && start) begin
      a_lat <= a_in;
      b_lat <= b_in;
      step  <= '0;
    end else if (fire) begin
      step <= step + 3'd1;
      if (!step[0]) begin
        acc <= widen(mul_p);
      end else begin
        shadow[step[2:1]] <= sum;
        // The last sum is still in flight, so c11 takes it directly.
        if (step == 3'd7) begin
          c00 <= shadow[0];
          c01 <= shadow[1];
          c10 <= shadow[2];
          c11 <= sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_matmul_mac_sched.sv
module tb_matmul_mac_sched;

  localparam int W  = 8;
  localparam int RW = 2*W+1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [4*W-1:0]    a_in, b_in;
  logic              mul_req, mul_gnt;
  logic [W-1:0]      mul_a, mul_b;
  logic [2*W-1:0]    mul_p;
  logic              busy, done;
  logic [RW-1:0]     c00, c01, c10, c11;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [4*RW-1:0] sb [$];
  logic [4*RW-1:0] exp_r, got_r;

  always #5 clk = ~clk;

  // Shared multiplier stand-in
  assign mul_p = mul_a * mul_b;

  matmul_mac_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .mul_req(mul_req), .mul_gnt(mul_gnt), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .busy(busy), .done(done),
    .c00(c00), .c01(c01), .c10(c10), .c11(c11)
  );

  function automatic logic [4*W-1:0] pk(input int e0, input int e1,
                                        input int e2, input int e3);
    return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  // Reference 2x2 matrix product, packed {c00,c01,c10,c11}
  function automatic logic [4*RW-1:0] model(input logic [4*W-1:0] a,
                                            input logic [4*W-1:0] b);
    int ai [4];
    int bi [4];
    int r00, r01, r10, r11;
    for (int i = 0; i < 4; i++) begin
      ai[i] = int'(a[i*W +: W]);
      bi[i] = int'(b[i*W +: W]);
    end
    r00 = ai[0]*bi[0] + ai[1]*bi[2];
    r01 = ai[0]*bi[1] + ai[1]*bi[3];
    r10 = ai[2]*bi[0] + ai[3]*bi[2];
    r11 = ai[2]*bi[1] + ai[3]*bi[3];
    return {RW'(r00), RW'(r01), RW'(r10), RW'(r11)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Advance until done is seen or the budget runs out.
  task automatic wait_done(input int budget, output bit seen, output int cnt);
    seen = 1'b0;
    cnt  = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      cyc();
      cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mul_gnt = 1'b1; a_in = '0; b_in = '0;
    cyc(); cyc();
    n_cmp++;
    if ({busy, done, mul_req} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctrl got busy/done/req=%b want 000", {busy, done, mul_req});
    end
    n_cmp++;
    if ({c00, c01, c10, c11, mul_a, mul_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got c=%h a=%h b=%h want 0", {c00, c01, c10, c11}, mul_a, mul_b);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    bit bad = 1'b0;
    a_in = pk(1, 2, 3, 4); b_in = pk(5, 6, 7, 8); mul_gnt = 1'b1;
    start = 1'b1; sb.push_back(model(a_in, b_in));
    cyc(); start = 1'b0;              // cycle T+1
    n_cmp++;
    if ({busy, mul_req} !== 2'b11) begin
      n_fail++;
      $display("FAIL basic_busy_req got %b want 11", {busy, mul_req});
    end
    for (int i = 0; i < 8; i++) begin
      if (!mul_req || done) bad = 1'b1;
      cyc();
    end                               // cycle T+9
    n_cmp++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_req_window got bad=%b want 0", bad);
    end
    n_cmp++;
    if ({done, busy, mul_req} !== 3'b100) begin
      n_fail++;
      $display("FAIL basic_done_T9 got done/busy/req=%b want 100", {done, busy, mul_req});
    end
    n_cmp++;
    if ({c00, c01, c10, c11} !== {17'd19, 17'd22, 17'd43, 17'd50}) begin
      n_fail++;
      $display("FAIL basic_const got %0d %0d %0d %0d want 19 22 43 50", c00, c01, c10, c11);
    end
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL basic_sb got empty queue want entry");
    end else begin
      exp_r = sb.pop_front(); got_r = {c00, c01, c10, c11};
      if (got_r !== exp_r) begin
        n_fail++;
        $display("FAIL basic_results got %h want %h", got_r, exp_r);
      end
    end
    cyc();
    n_cmp++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_width got %b want 0", done);
    end
  endtask

  task automatic test_max();
    bit seen; int cnt;
    a_in = pk(255, 255, 255, 255); b_in = a_in;
    start = 1'b1; sb.push_back(model(a_in, b_in));
    cyc(); start = 1'b0;
    wait_done(20, seen, cnt);
    n_cmp++;
    if (!seen || cnt != 8) begin
      n_fail++;
      $display("FAIL max_latency got seen=%0d cnt=%0d want 1 8", seen, cnt);
    end
    n_cmp++;
    if ({c00, c01, c10, c11} !== {4{17'h1FC02}}) begin
      n_fail++;
      $display("FAIL max_const got %h %h %h %h want 1fc02", c00, c01, c10, c11);
    end
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL max_sb got empty queue want entry");
    end else begin
      exp_r = sb.pop_front(); got_r = {c00, c01, c10, c11};
      if (got_r !== exp_r) begin
        n_fail++;
        $display("FAIL max_results got %h want %h", got_r, exp_r);
      end
    end
    cyc();
  endtask

  task automatic test_stall();
    int idx = 1;
    bit prev_stall = 1'b0;
    bit req_bad = 1'b0;
    logic [W-1:0] pa = '0, pb = '0;
    a_in = pk(1, 2, 3, 4); b_in = pk(5, 6, 7, 8);
    start = 1'b1; sb.push_back(model(a_in, b_in));
    cyc(); start = 1'b0;              // cycle T+1
    while (!done && idx < 40) begin
      mul_gnt = (idx % 2 == 0);
      if (!mul_req) req_bad = 1'b1;
      if (prev_stall) begin
        n_cmp++;
        if ({mul_a, mul_b} !== {pa, pb}) begin
          n_fail++;
          $display("FAIL stall_hold got %0d,%0d want %0d,%0d", mul_a, mul_b, pa, pb);
        end
      end
      prev_stall = !mul_gnt; pa = mul_a; pb = mul_b;
      cyc(); idx++;
    end
    mul_gnt = 1'b1;
    n_cmp++;
    if (!done || idx != 17) begin
      n_fail++;
      $display("FAIL stall_latency got done=%b at T+%0d want 1 at T+17", done, idx);
    end
    n_cmp++;
    if (req_bad !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_req_drop got %b want 0", req_bad);
    end
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL stall_sb got empty queue want entry");
    end else begin
      exp_r = sb.pop_front(); got_r = {c00, c01, c10, c11};
      if (got_r !== exp_r) begin
        n_fail++;
        $display("FAIL stall_results got %h want %h", got_r, exp_r);
      end
    end
    cyc();
  endtask

  task automatic test_ignore_start();
    bit seen; int cnt;
    a_in = pk(1, 2, 3, 4); b_in = pk(5, 6, 7, 8);
    start = 1'b1; sb.push_back(model(a_in, b_in));
    cyc(); start = 1'b0;
    wait_done(20, seen, cnt);
    n_cmp++;
    if (sb.size() == 0 || !seen) begin
      n_fail++;
      $display("FAIL ign_job1 got seen=%0d want 1", seen);
    end else begin
      exp_r = sb.pop_front(); got_r = {c00, c01, c10, c11};
      if (got_r !== exp_r) begin
        n_fail++;
        $display("FAIL ign_job1 got %h want %h", got_r, exp_r);
      end
    end
    a_in = pk(1, 0, 0, 1); b_in = pk(9, 8, 7, 6);
    start = 1'b1; sb.push_back(model(a_in, b_in));
    cyc(); start = 1'b0;              // T+1
    cyc(); cyc();                     // T+3
    start = 1'b1; a_in = pk(50, 60, 70, 80); b_in = pk(11, 12, 13, 14);
    cyc(); start = 1'b0;              // T+4
    n_cmp++;
    if ({c00, c01, c10, c11} !== {17'd19, 17'd22, 17'd43, 17'd50}) begin
      n_fail++;
      $display("FAIL ign_hold got %0d %0d %0d %0d want 19 22 43 50", c00, c01, c10, c11);
    end
    wait_done(20, seen, cnt);
    n_cmp++;
    if (!seen || cnt != 5) begin
      n_fail++;
      $display("FAIL ign_latency got seen=%0d cnt=%0d want 1 5", seen, cnt);
    end
    n_cmp++;
    if ({c00, c01, c10, c11} !== {17'd9, 17'd8, 17'd7, 17'd6}) begin
      n_fail++;
      $display("FAIL ign_const got %0d %0d %0d %0d want 9 8 7 6", c00, c01, c10, c11);
    end
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL ign_sb got empty queue want entry");
    end else begin
      exp_r = sb.pop_front(); got_r = {c00, c01, c10, c11};
      if (got_r !== exp_r) begin
        n_fail++;
        $display("FAIL ign_results got %h want %h", got_r, exp_r);
      end
    end
    cyc();
    wait_done(12, seen, cnt);
    n_cmp++;
    if (seen !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_no_queue got done=%0d busy=%b want 0 0", seen, busy);
    end
  endtask

  task automatic test_back_to_back();
    int since = 1, jobs = 0;
    bit busy_bad = 1'b0;
    a_in = $urandom; b_in = $urandom;
    start = 1'b1; sb.push_back(model(a_in, b_in));
    cyc();                            // T+1
    for (int i = 0; i < 40 && jobs < 3; i++) begin
      if (done) begin
        n_cmp++;
        if (since != 9 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_period got since=%0d busy=%b want 9 0", since, busy);
        end
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_sb got empty queue want entry");
        end else begin
          exp_r = sb.pop_front(); got_r = {c00, c01, c10, c11};
          if (got_r !== exp_r) begin
            n_fail++;
            $display("FAIL b2b_results got %h want %h", got_r, exp_r);
          end
        end
        jobs++;
        if (jobs < 3) begin
          a_in = $urandom; b_in = $urandom;
          sb.push_back(model(a_in, b_in));
        end else begin
          start = 1'b0;
        end
        since = 0;
      end else if (!busy) begin
        busy_bad = 1'b1;
      end
      cyc(); since++;
    end
    start = 1'b0;
    n_cmp++;
    if (jobs != 3 || busy_bad !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_jobs got jobs=%0d busy_bad=%b want 3 0", jobs, busy_bad);
    end
  endtask

  task automatic test_reset_abort();
    bit seen; int cnt;
    a_in = pk(3, 1, 4, 1); b_in = pk(5, 9, 2, 6);
    start = 1'b1;
    cyc(); start = 1'b0;              // T+1
    cyc(); cyc(); cyc();              // T+4
    rst = 1'b1;
    cyc(); rst = 1'b0;
    n_cmp++;
    if ({busy, mul_req, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_ctrl got busy/req/done=%b want 000", {busy, mul_req, done});
    end
    n_cmp++;
    if ({c00, c01, c10, c11} !== '0) begin
      n_fail++;
      $display("FAIL abort_results got %h want 0", {c00, c01, c10, c11});
    end
    wait_done(15, seen, cnt);
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done got %0d want 0", seen);
    end
    start = 1'b1; sb.push_back(model(a_in, b_in));
    cyc(); start = 1'b0;
    wait_done(20, seen, cnt);
    n_cmp++;
    if (!seen || cnt != 8) begin
      n_fail++;
      $display("FAIL abort_rerun_latency got seen=%0d cnt=%0d want 1 8", seen, cnt);
    end
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL abort_sb got empty queue want entry");
    end else begin
      exp_r = sb.pop_front(); got_r = {c00, c01, c10, c11};
      if (got_r !== exp_r) begin
        n_fail++;
        $display("FAIL abort_rerun_results got %h want %h", got_r, exp_r);
      end
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_stall();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover got %0d entries want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
